// File: rtl/rr_merge_pkg.sv
// rr_merge_pkg -- shared definitions for the rr_merge N-to-1 bus merge.
//   state_e      : controller state (IDLE waits for a request, BUSY holds a grant)
//   CNT_W        : width of the optional per-master completion counters
//   clog2_min1() : index width that stays at least one bit wide for N=1
//   req_mw()     : width of one request slice  {valid, addr, wdata, wstrb}
//   resp_mw()    : width of one response slice {rdata, ready}
package rr_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int CNT_W = 32;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int req_mw(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_mw(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin / fixed-priority winner selection.
//   N, FIXED_PRIO : number of requesters; FIXED_PRIO=1 makes index 0 highest
//                   priority and ignores the pointer
//   req_i         : request vector, one bit per requester
//   rr_ptr_i      : index that has highest priority this round
//   grant_oh_o    : one-hot winner (all zero when nothing requests)
//   grant_o       : binary winner index
//   any_o         : at least one requester is active
module rr_arbiter
    import rr_merge_pkg::*;
#(
    parameter int N          = 2,
    parameter int FIXED_PRIO = 0,
    localparam int PTR_W     = clog2_min1(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [PTR_W-1:0] grant_o,
    output logic             any_o
);

    logic [PTR_W-1:0] base;
    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_rot;

    assign base    = (FIXED_PRIO != 0) ? '0 : rr_ptr_i;
    // Doubling the vector turns the wrap-around search into a plain shift:
    // bit k of the shifted vector is requester (base + k) mod N.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl >> base;

    always_comb begin
        int sum;
        grant_o = '0;
        any_o   = 1'b0;
        sum     = 0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_rot[k]) begin
                any_o = 1'b1;
                sum   = int'(base) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                grant_o = PTR_W'(sum);
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_oh
        assign grant_oh_o[gi] = any_o && (grant_o == PTR_W'(gi));
    end

endmodule

// File: rtl/rr_merge.sv
// rr_merge -- N-master to 1-slave native-bus merge with registered arbitration.
// A grant is taken in IDLE (one cycle after a request is seen) and held in
// BUSY until the slave answers with ready, so there is one bubble cycle
// between transactions.
//   clk, rst : clock and synchronous active-high reset
//   m_req    : per master {valid, addr, wdata, wstrb}, master i at slice i
//   m_resp   : per master {rdata, ready}; only the granted master sees data
//   s_req    : request forwarded to the slave (same slice layout)
//   s_resp   : slave {rdata, ready}
// Optional build macro RR_MERGE_CNT_EN adds cnt_clr (in) and cnt (out,
// N_MASTERS*32): saturating per-master counts of completed transactions.
module rr_merge
    import rr_merge_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIXED_PRIO = 0,
    localparam int REQ_MW    = req_mw(ADDR_W, DATA_W),
    localparam int RESP_MW   = resp_mw(DATA_W)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS*REQ_MW-1:0]    m_req,
    output logic [N_MASTERS*RESP_MW-1:0]   m_resp,
    output logic [REQ_MW-1:0]              s_req,
    input  logic [RESP_MW-1:0]             s_resp
`ifdef RR_MERGE_CNT_EN
    ,
    input  logic                           cnt_clr,
    output logic [N_MASTERS*CNT_W-1:0]     cnt
`endif
);

    localparam int PTR_W     = clog2_min1(N_MASTERS);
    localparam int VALID_BIT = REQ_MW - 1;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic [N_MASTERS-1:0]   grant_oh_q, grant_oh_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [REQ_MW-1:0]      req_arr [N_MASTERS];
    logic [N_MASTERS-1:0]   m_valid;
    logic [REQ_MW-1:0]      req_sel;
    logic [N_MASTERS-1:0]   win_oh;
    logic [PTR_W-1:0]       win;
    logic                   win_any;
    logic                   leave;
    logic                   done;

    genvar gi;
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
        assign req_arr[gi] = m_req[gi*REQ_MW +: REQ_MW];
        assign m_valid[gi] = req_arr[gi][VALID_BIT];
    end

    assign req_sel = req_arr[grant_q];

    rr_arbiter #(
        .N          (N_MASTERS),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req_i      (m_valid),
        .rr_ptr_i   (rr_ptr_q),
        .grant_oh_o (win_oh),
        .grant_o    (win),
        .any_o      (win_any)
    );

    // A granted master dropping valid ends the transaction just like a
    // completion, except that no response is passed back.
    assign leave = (state_q == BUSY) && (!req_sel[VALID_BIT] || s_resp[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    grant_d    = win;
                    grant_oh_d = win_oh;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (leave) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == PTR_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_req = '0;
        done  = 1'b0;
        if (state_q == BUSY) begin
            s_req = req_sel;
            done  = req_sel[VALID_BIT] & s_resp[0];
        end
    end

    for (gi = 0; gi < N_MASTERS; gi++) begin : g_resp
        assign m_resp[gi*RESP_MW +: RESP_MW] = (done && grant_oh_q[gi]) ? s_resp : '0;
    end

`ifdef RR_MERGE_CNT_EN
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                cnt_q <= '0;
            end else if (done && grant_oh_q[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_rr_merge.sv
// tb_rr_merge -- scoreboard bench for rr_merge.
// Two instances share the master stimulus: u_rr (round-robin) and u_fp
// (fixed priority); the one not in use is held in reset and isolated from
// the slave model. Expected responses are queued when stimulus is issued and
// popped by a negedge monitor whenever a master sees ready.
`timescale 1ns/1ps
module tb_rr_merge;
    localparam int N       = 4;
    localparam int DW      = 256;
    localparam int AW      = 32;
    localparam int SW      = DW / 8;
    localparam int REQ_MW  = 1 + AW + DW + SW;
    localparam int RESP_MW = DW + 1;
    localparam int CW      = N * RESP_MW;
    localparam logic [AW-1:0] KEY = 32'h5A5A_A5A5;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic          mv     [N];
    logic [AW-1:0] maddr  [N];
    logic [DW-1:0] mwdata [N];
    logic [SW-1:0] mwstrb [N];
    int            left   [N];

    logic [N*REQ_MW-1:0]  m_req;
    logic [CW-1:0]        m_resp_a, m_resp_b, m_resp;
    logic [REQ_MW-1:0]    s_req_a, s_req_b, s_req;
    logic [RESP_MW-1:0]   s_resp, s_resp_a, s_resp_b;
    logic                 s_rdy;
    logic [DW-1:0]        s_rdata;
    logic                 rst_a, rst_b;
    logic [N-1:0]         rdy_seen;

    int   w;
    int   lat;
    bit   use_fixed;
    logic [DW-1:0] fixed_rdata;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always_comb begin
        m_req = '0;
        for (int i = 0; i < N; i++) begin
            m_req[i*REQ_MW +: REQ_MW] = {mv[i], maddr[i], mwdata[i], mwstrb[i]};
        end
    end

    assign s_resp   = {s_rdata, s_rdy};
    assign s_resp_a = sel ? '0 : s_resp;
    assign s_resp_b = sel ? s_resp : '0;
    assign rst_a    = rst | sel;
    assign rst_b    = rst | ~sel;
    assign m_resp   = sel ? m_resp_b : m_resp_a;
    assign s_req    = sel ? s_req_b : s_req_a;

`ifdef RR_MERGE_CNT_EN
    logic            cnt_clr;
    logic [N*32-1:0] cnt_a, cnt_b;
`endif

    rr_merge #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0)) u_rr (
        .clk    (clk),
        .rst    (rst_a),
        .m_req  (m_req),
        .m_resp (m_resp_a),
        .s_req  (s_req_a),
        .s_resp (s_resp_a)
`ifdef RR_MERGE_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .cnt    (cnt_a)
`endif
    );

    rr_merge #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1)) u_fp (
        .clk    (clk),
        .rst    (rst_b),
        .m_req  (m_req),
        .m_resp (m_resp_b),
        .s_req  (s_req_b),
        .s_resp (s_resp_b)
`ifdef RR_MERGE_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .cnt    (cnt_b)
`endif
    );

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return {8{a ^ KEY}};
    endfunction

    function automatic logic [REQ_MW-1:0] exp_req(input logic v, input logic [AW-1:0] a,
                                                  input logic [DW-1:0] d, input logic [SW-1:0] s);
        return {v, a, d, s};
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] r);
        exp_t e;
        e.idx   = i;
        e.rdata = r;
        sb_q.push_back(e);
    endtask

    task automatic issue(input int i, input int n, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        mv[i]     = 1'b1;
        maddr[i]  = a;
        mwdata[i] = d;
        mwstrb[i] = s;
        left[i]   = n - 1;
    endtask

    // One clock: masters react to last cycle's ready, then the slave model.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy_seen[i] && mv[i]) begin
                if (left[i] > 0) begin
                    left[i]  = left[i] - 1;
                    maddr[i] = maddr[i] + 4;
                end else begin
                    mv[i] = 1'b0;
                end
            end
        end
        #1;
        if (rst || s_rdy) begin
            s_rdy = 1'b0;
            w     = 0;
        end else if (s_req[REQ_MW-1]) begin
            if (w >= lat) begin
                s_rdy   = 1'b1;
                s_rdata = use_fixed ? fixed_rdata : rd_of(s_req[REQ_MW-2 -: AW]);
            end else begin
                w++;
            end
        end else begin
            w = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic bit any_mv();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r |= mv[i];
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((sb_q.size() != 0 || any_mv()) && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout: %0d responses outstanding after %0d cycles", sb_q.size(), budget);
        end
        tick();
        tick();
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!s_req[REQ_MW-1] && k < budget);
        n_cmp++;
        if (!s_req[REQ_MW-1]) begin
            n_bad++;
            $display("FAIL busy_timeout: s valid got 0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Monitor: every ready a master sees must match the head of the queue.
    always @(negedge clk) begin : mon
        exp_t          e;
        logic [CW-1:0] others;
        for (int i = 0; i < N; i++) begin
            rdy_seen[i] = m_resp[i*RESP_MW];
            if (m_resp[i*RESP_MW]) begin
                others = m_resp;
                others[i*RESP_MW +: RESP_MW] = '0;
                check("others_zero", others, '0);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: master %0d got ready, expected none", i);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_master", CW'(i), CW'(e.idx));
                    check("resp_rdata", CW'(m_resp[i*RESP_MW+1 +: DW]), CW'(e.rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] wpat;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; maddr[i] = '0; mwdata[i] = '0; mwstrb[i] = '0; left[i] = 0;
        end
        rdy_seen = '0; s_rdy = 1'b0; s_rdata = '0; w = 0; lat = 0;
        use_fixed = 1'b0; fixed_rdata = '0;
`ifdef RR_MERGE_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Reset then idle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            check("idle_s_req", CW'(s_req_a), '0);
            check("idle_m_resp", m_resp_a, '0);
        end

        // Single read from master 1, slave answers after a few cycles
        lat = 3; use_fixed = 1'b1; fixed_rdata = DW'(32'hCAFE_F00D);
        tick();
        issue(1, 1, 32'h100, '0, '0);
        push(1, fixed_rdata);
        @(negedge clk);
        check("arb_latency_valid", CW'(s_req[REQ_MW-1]), CW'(0));
        tick();
        @(negedge clk);
        check("read_fwd", CW'(s_req), CW'(exp_req(1'b1, 32'h100, '0, '0)));
        wait_idle(40);
        use_fixed = 1'b0;

        // Round-robin fairness: all four request continuously, 4 each
        do_reset(); lat = 0;
        for (int i = 0; i < N; i++) issue(i, 4, AW'(32'h1000 * (i + 1)), DW'(i), '0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) push(i, rd_of(AW'(32'h1000 * (i + 1) + 4 * r)));
        end
        wait_idle(200);
`ifdef RR_MERGE_CNT_EN
        for (int i = 0; i < N; i++) check("cnt_after_rr", CW'(cnt_a[i*32 +: 32]), CW'(4));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("cnt_cleared", CW'(cnt_a), '0);
`endif

        // Fixed priority: m0 (three requests) starves m2 until it stops
        sel = 1'b1;
        do_reset(); lat = 1;
        issue(0, 3, 32'h5000, '0, '0);
        issue(2, 1, 32'h5200, '0, '0);
        push(0, rd_of(32'h5000));
        push(0, rd_of(32'h5004));
        push(0, rd_of(32'h5008));
        push(2, rd_of(32'h5200));
        wait_idle(100);

        // Abort: m2 drops valid while BUSY; pointer must still advance
        sel = 1'b0;
        do_reset(); lat = 10;
        issue(2, 1, 32'h6200, '0, '0);
        wait_busy(10);
        mv[2] = 1'b0;
        @(negedge clk);
        check("abort_s_valid", CW'(s_req[REQ_MW-1]), CW'(0));
        tick();
        @(negedge clk);
        check("abort_idle_s_req", CW'(s_req), '0);
        tick();
        lat = 0;
        issue(2, 1, 32'h6210, '0, '0);
        issue(3, 1, 32'h6300, '0, '0);
        push(3, rd_of(32'h6300));
        push(2, rd_of(32'h6210));
        wait_idle(50);

        // Reset while BUSY: transaction dropped, pointer back to 0
        lat = 10;
        issue(1, 1, 32'h7100, '0, '0);
        wait_busy(10);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_s_req", CW'(s_req), '0);
        check("rst_m_resp", m_resp, '0);
        issue(3, 1, 32'h7300, '0, '0);
        rst = 1'b0; lat = 0;
        push(1, rd_of(32'h7100));
        push(3, rd_of(32'h7300));
        wait_idle(50);

        // Wide write from m0: forwarded slice must be bit-exact
        do_reset(); lat = 1;
        for (int j = 0; j < 8; j++) wpat[j*32 +: 32] = (32'h1111_1111 * j) ^ 32'hA5A5_0000;
        issue(0, 1, 32'h8000, wpat, '1);
        push(0, rd_of(32'h8000));
        wait_busy(10);
        @(negedge clk);
        check("write_fwd", CW'(s_req), CW'(exp_req(1'b1, 32'h8000, wpat, '1)));
        wait_idle(40);
        @(negedge clk);
        check("final_m_resp", m_resp, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
